// File: rtl/riscv_pipeline_pkg.sv
// rtl/riscv_pipeline_pkg.sv - shared pipeline typedefs and memory-arbiter defaults
package riscv_pipeline_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_t;

  localparam int STARVE_MAX_DEF = 4;
  localparam int TIMEOUT_DEF    = 16;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != W'(MAX))) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-port memory with
// starvation guard and ack timeout
module mem_port_arbiter
  import riscv_pipeline_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              i_err,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int SW = cnt_width(STARVE_MAX);
  localparam int WW = cnt_width(TIMEOUT);

  arb_state_t    state;
  logic [SW-1:0] starve_cnt;
  logic [WW-1:0] wait_cnt;

  logic i_elig, d_elig, retire, pick_i, grant_i, grant_d;
  logic busy, timeout_hit;

  assign i_elig = i_req & ~i_done & ~i_err;
  assign d_elig = d_req & ~d_done & ~d_err;
  assign retire = i_done | d_done | i_err | d_err;

  // No grant while a completion is pulsing: the retire cycle is a turnaround,
  // so a back-to-back requester is not skipped and the starvation count rules.
  assign pick_i  = i_elig & (~d_elig | (starve_cnt == SW'(STARVE_MAX)));
  assign grant_i = (state == ST_IDLE) & ~retire & pick_i;
  assign grant_d = (state == ST_IDLE) & ~retire & d_elig & ~pick_i;

  assign busy        = (state != ST_IDLE);
  assign timeout_hit = busy & ~mem_ack & (wait_cnt == WW'(TIMEOUT - 1));

  assign stall_if  = i_req & ~i_done & ~i_err;
  assign stall_mem = d_req & ~d_done & ~d_err;

  sat_counter #(.W(SW), .MAX(STARVE_MAX)) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (grant_d & i_req),
    .clr   (grant_i | ~i_req),
    .cnt   (starve_cnt)
  );

  sat_counter #(.W(WW), .MAX(TIMEOUT)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (busy & ~mem_ack),
    .clr   (~busy | mem_ack),
    .cnt   (wait_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      i_err     <= 1'b0;
      d_err     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      i_err  <= 1'b0;
      d_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_i) begin
            state     <= ST_BUSY_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
          end else if (grant_d) begin
            state     <= ST_BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          if (mem_ack) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
            if (state == ST_BUSY_I) begin
              i_done  <= 1'b1;
              i_rdata <= mem_rdata;
            end else begin
              d_done  <= 1'b1;
              d_rdata <= mem_rdata;
            end
          end else if (timeout_hit) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
            if (state == ST_BUSY_I) i_err <= 1'b1;
            else                    d_err <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_done, d_done, i_err, d_err;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          stall_if, stall_mem;

  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            ack_lat = 0;
  bit            ack_en = 1'b1;
  bit            stray_ack = 1'b0;
  int            req_age = 0;
  logic [DW-1:0] rd_val = '0;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .i_err(i_err), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Memory acks in BUSY cycle number ack_lat+1 (ack_lat=0: same cycle as first mem_req).
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mem_req) req_age++;
    else         req_age = 0;
    mem_ack   = stray_ack || (mem_req && ack_en && (req_age == ack_lat + 1));
    mem_rdata = rd_val;
    #1;
  endtask

  initial begin
    int t0, busy_n, err_n, done_n, pulses;
    bit ok;
    int owners[$];
    logic prev_req;

    reset = 1'b1; i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_ack = 0; mem_rdata = '0;
    tick(); tick();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_pulses", {i_done, d_done, i_err, d_err}, 0);
    check("rst_rdata", {i_rdata, d_rdata}, 0);
    check("rst_stalls", {stall_if, stall_mem}, 0);
    reset = 1'b0;
    tick();

    // Fetch only, ack one cycle after mem_req rises
    ack_lat = 1; rd_val = 32'h00700093;
    i_req = 1; i_addr = 32'h04; t0 = cyc;
    tick();
    check("f_mem_req", mem_req, 1);
    check("f_mem_addr", mem_addr, 32'h04);
    check("f_mem_we", mem_we, 0);
    check("f_stall_if", stall_if, 1);
    tick();
    check("f_no_early_done", i_done, 0);
    tick();
    check("f_i_done", i_done, 1);
    check("f_latency", cyc - t0, 3);
    check("f_i_rdata", i_rdata, 32'h00700093);
    check("f_mem_req_low", mem_req, 0);
    check("f_stall_if_low", stall_if, 0);
    i_req = 0;
    tick();
    check("f_done_once", i_done, 0);

    // Stray ack while idle
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    tick(); tick();
    check("stray_no_req", mem_req, 0);
    check("stray_no_pulse", {i_done, d_done, i_err, d_err}, 0);

    // Simultaneous fetch and store: data first
    ack_lat = 0;
    i_req = 1; i_addr = 32'h08;
    d_req = 1; d_we = 1; d_addr = 32'h00; d_wdata = 32'h7;
    tick();
    check("s_d_first_we", mem_we, 1);
    check("s_d_wdata", mem_wdata, 32'h7);
    check("s_d_addr", mem_addr, 32'h0);
    check("s_stall_if1", stall_if, 1);
    tick();
    check("s_d_done", d_done, 1);
    check("s_stall_mem_low", stall_mem, 0);
    check("s_stall_if2", stall_if, 1);
    d_req = 0;
    tick();
    check("s_turnaround", mem_req, 0);
    check("s_stall_if3", stall_if, 1);
    tick();
    check("s_i_req", mem_req, 1);
    check("s_i_addr", mem_addr, 32'h08);
    check("s_i_we", mem_we, 0);
    check("s_stall_if4", stall_if, 1);
    tick();
    check("s_i_done", i_done, 1);
    check("s_stall_if_low", stall_if, 0);
    i_req = 0;
    tick();

    // Starvation: d held back-to-back, 5th grant must go to fetch
    i_req = 1; i_addr = 32'h10;
    d_req = 1; d_we = 0; d_addr = 32'h20;
    prev_req = mem_req;
    for (int k = 0; k < 40 && owners.size() < 5; k++) begin
      tick();
      if (mem_req && !prev_req) owners.push_back((mem_addr == 32'h20) ? 1 : 0);
      prev_req = mem_req;
    end
    check("starve_grant_count", owners.size(), 5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("starve_grant%0d_is_d", k),
            (owners.size() > k) ? owners[k] : 99, (k < 4) ? 1 : 0);
    end
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (i_done) begin ok = 1; break; end
    end
    check("starve_i_done", ok, 1);
    i_req = 0;
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (d_done) begin ok = 1; break; end
    end
    check("starve_d_done_after", ok, 1);
    d_req = 0;
    tick();

    // Timeout on a load that is never acked
    ack_en = 1'b0;
    d_req = 1; d_we = 0; d_addr = 32'h30;
    busy_n = 0; err_n = 0; done_n = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (mem_req) busy_n++;
      if (d_err) begin err_n++; d_req = 0; end
      if (d_done) done_n++;
    end
    check("to_busy_cycles", busy_n, 16);
    check("to_d_err_once", err_n, 1);
    check("to_no_d_done", done_n, 0);
    check("to_mem_req_low", mem_req, 0);
    ack_en = 1'b1;

    // Reset in the second BUSY_D cycle
    ack_lat = 5;
    d_req = 1; d_we = 0; d_addr = 32'h40;
    tick();
    tick();
    check("rm_busy_before", mem_req, 1);
    reset = 1'b1;
    tick();
    check("rm_mem_req", mem_req, 0);
    check("rm_no_pulse", {i_done, d_done, i_err, d_err}, 0);
    reset = 1'b0; d_req = 0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (i_done || d_done || i_err || d_err || mem_req) pulses++;
    end
    check("rm_quiet_after", pulses, 0);
    ack_lat = 0; rd_val = 32'h12345678;
    i_req = 1; i_addr = 32'h80;
    tick();
    check("rm_fresh_req", mem_req, 1);
    check("rm_fresh_addr", mem_addr, 32'h80);
    tick();
    check("rm_fresh_done", i_done, 1);
    check("rm_fresh_rdata", i_rdata, 32'h12345678);
    i_req = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
